// File: rtl/evt_buf_alloc_ctrl.sv
// rtl/evt_buf_alloc_ctrl.sv - LV2 event buffer space allocator and round-robin burst write scheduler
module evt_buf_alloc_ctrl #(
    parameter int              NREQ       = 4,
    parameter int              AW         = 18,
    parameter int              LEN_W      = 12,
    parameter logic [AW-1:0]   HIGH_WATER = 18'd200000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    input  logic                   wr_valid,
    output logic [NREQ-1:0]        grant,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic                   burst_done,
    input  logic                   free_valid,
    input  logic [LEN_W-1:0]       free_len,
    output logic [AW-1:0]          current_mem_usage,
    output logic                   almost_full,
    output logic                   free_err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = ((AW > LEN_W) ? AW : LEN_W) + 1;
    localparam logic [SW-1:0] CAP = SW'((64'd1 << AW) - 64'd1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_ptr, cur_q, cand, idx;
    logic [LEN_W-1:0]  len_q, cnt_q, cand_len;
    logic [AW-1:0]     wptr;
    logic              found, fits, do_grant, hold_rr, beat, last;
    logic [SW-1:0]     alloc, sum, rel;
    logic              over;

    // Candidate is the first requester at or after the rr pointer.
    always_comb begin
        found    = 1'b0;
        cand     = rr_ptr;
        idx      = '0;
        cand_len = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((k + int'(rr_ptr)) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (cand == IW'(i)) cand_len = req_len[i*LEN_W +: LEN_W];
        end
        fits = (SW'(current_mem_usage) + SW'(cand_len)) <= CAP;
    end

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        hold_rr  = 1'b0;
        beat     = 1'b0;
        last     = 1'b0;
        alloc    = '0;
        case (state_q)
            IDLE: begin
                if (found && fits) begin
                    do_grant = 1'b1;
                    alloc    = SW'(cand_len);
                    state_d  = BURST;
                end else if (found) begin
                    hold_rr = 1'b1;
                end
            end
            BURST: begin
                if (len_q == '0) begin
                    last    = 1'b1;
                    state_d = DONE;
                end else if (wr_valid) begin
                    beat = 1'b1;
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        last    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Release larger than what is (or is being) allocated clamps to empty.
    always_comb begin
        sum  = SW'(current_mem_usage) + alloc;
        rel  = free_valid ? SW'(free_len) : '0;
        over = rel > sum;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            grant             <= '0;
            rr_ptr            <= '0;
            cur_q             <= '0;
            len_q             <= '0;
            cnt_q             <= '0;
            wptr              <= '0;
            current_mem_usage <= '0;
            almost_full       <= 1'b0;
            free_err          <= 1'b0;
        end else begin
            state_q           <= state_d;
            current_mem_usage <= over ? '0 : AW'(sum - rel);
            almost_full       <= current_mem_usage >= HIGH_WATER;
            if (over) free_err <= 1'b1;
            if (do_grant) begin
                grant <= NREQ'(1) << cand;
                len_q <= cand_len;
                cnt_q <= '0;
                cur_q <= cand;
            end
            if (beat) begin
                wptr  <= wptr + AW'(1);
                cnt_q <= cnt_q + LEN_W'(1);
            end
            if (last) grant <= '0;
            if (hold_rr) rr_ptr <= cand;
            if (state_q == DONE) rr_ptr <= (cur_q == IW'(NREQ - 1)) ? '0 : cur_q + IW'(1);
        end
    end

    assign wr_en      = (state_q == BURST) && wr_valid && (len_q != '0);
    assign wr_addr    = wptr;
    assign burst_done = (state_q == DONE);
endmodule

// File: tb/tb_evt_buf_alloc_ctrl.sv
// tb/tb_evt_buf_alloc_ctrl.sv - directed self-checking bench for evt_buf_alloc_ctrl
module tb_evt_buf_alloc_ctrl;
    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [47:0] req_len;
    logic        wr_valid;
    logic [3:0]  grant;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic        burst_done;
    logic        free_valid;
    logic [11:0] free_len;
    logic [7:0]  usage;
    logic        almost_full;
    logic        free_err;

    int checks = 0;
    int errors = 0;

    // Small address space keeps buffer-full and pointer-wrap cases short.
    evt_buf_alloc_ctrl #(.NREQ(4), .AW(8), .LEN_W(12), .HIGH_WATER(8'd200)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .wr_valid(wr_valid),
        .grant(grant), .wr_en(wr_en), .wr_addr(wr_addr), .burst_done(burst_done),
        .free_valid(free_valid), .free_len(free_len), .current_mem_usage(usage),
        .almost_full(almost_full), .free_err(free_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; req_len = '0; wr_valid = 1'b0;
        free_valid = 1'b0; free_len = '0;
        run(2);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h exp 00", wr_addr); end
        checks++; if (usage !== 8'd0) begin errors++; $display("FAIL reset_usage got %0d exp 0", usage); end
        checks++; if ({almost_full, free_err, burst_done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {almost_full, free_err, burst_done}); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req = 4'b0001; req_len[0 +: 12] = 12'd4; wr_valid = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", grant); end
        checks++; if (usage !== 8'd4) begin errors++; $display("FAIL single_usage got %0d exp 4", usage); end
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({wr_en, wr_addr} !== {1'b1, 8'(i)}) begin errors++; $display("FAIL single_beat%0d got en %b addr %h exp en 1 addr %h", i, wr_en, wr_addr, 8'(i)); end
            tick();
        end
        checks++; if ({grant, burst_done} !== 5'b0000_1) begin errors++; $display("FAIL single_done got grant %b done %b exp 0000 1", grant, burst_done); end
        tick();
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b exp 0", burst_done); end
        // rr pointer now at port 1, so port 1 wins over port 0.
        req = 4'b0011; req_len[0 +: 12] = 12'd1; req_len[12 +: 12] = 12'd1;
        n = 0;
        while (grant == 4'b0000 && n < 10) begin tick(); n++; end
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_rr got %b exp 0010", grant); end
        req = 4'b0000;
        run(3);
    endtask

    task automatic test_contention();
        logic [3:0] exp_g [5];
        int addr, n;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; req_len = {4{12'd2}}; wr_valid = 1'b1; addr = 0;
        for (int b = 0; b < 5; b++) begin
            n = 0;
            while (grant == 4'b0000 && n < 10) begin tick(); n++; end
            checks++; if (grant !== exp_g[b]) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", b, grant, exp_g[b]); end
            if (b == 4) req = 4'b0000;
            for (int j = 0; j < 2; j++) begin
                checks++; if ({wr_en, wr_addr} !== {1'b1, 8'(addr)}) begin errors++; $display("FAIL cont_addr got en %b addr %h exp en 1 addr %h", wr_en, wr_addr, 8'(addr)); end
                addr++;
                tick();
            end
            if (b == 3) begin
                checks++; if (usage !== 8'd8) begin errors++; $display("FAIL cont_usage got %0d exp 8", usage); end
            end
        end
        run(2);
    endtask

    task automatic test_space();
        do_reset();
        req = 4'b0001; req_len[0 +: 12] = 12'd252; wr_valid = 1'b1;
        tick();
        req = 4'b0000;
        run(254);
        checks++; if (usage !== 8'd252) begin errors++; $display("FAIL space_preload got %0d exp 252", usage); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL space_almost_full got %b exp 1", almost_full); end
        req = 4'b0110; req_len[12 +: 12] = 12'd5; req_len[24 +: 12] = 12'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL space_blocked%0d got %b exp 0000", i, grant); end
        end
        free_valid = 1'b1; free_len = 12'd2;
        tick();
        free_valid = 1'b0;
        checks++; if ({grant, usage} !== {4'b0000, 8'd250}) begin errors++; $display("FAIL space_free got grant %b usage %0d exp 0000 250", grant, usage); end
        tick();
        checks++; if ({grant, usage} !== {4'b0010, 8'd255}) begin errors++; $display("FAIL space_grant got grant %b usage %0d exp 0010 255", grant, usage); end
        req = 4'b0000;
        run(8);
    endtask

    task automatic test_wrap();
        logic       pat  [5];
        logic [7:0] eadr [5];
        int pulses;
        pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        eadr = '{8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h01};
        do_reset();
        req = 4'b0001; req_len[0 +: 12] = 12'd254; wr_valid = 1'b1;
        tick();
        req = 4'b0000;
        run(256);
        free_valid = 1'b1; free_len = 12'd254;
        tick();
        free_valid = 1'b0;
        checks++; if ({usage, free_err} !== {8'd0, 1'b0}) begin errors++; $display("FAIL wrap_free got usage %0d err %b exp 0 0", usage, free_err); end
        req = 4'b0001; req_len[0 +: 12] = 12'd4;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant got %b exp 0001", grant); end
        req = 4'b0000;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = pat[i];
            #1;
            if (wr_en) pulses++;
            checks++; if ({wr_en, wr_addr} !== {pat[i], eadr[i]}) begin errors++; $display("FAIL wrap_beat%0d got en %b addr %h exp en %b addr %h", i, wr_en, wr_addr, pat[i], eadr[i]); end
            tick();
        end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL wrap_pulses got %0d exp 4", pulses); end
        wr_valid = 1'b1;
        #1;
        checks++; if ({grant, burst_done, wr_en} !== 6'b0000_1_0) begin errors++; $display("FAIL wrap_done got grant %b done %b en %b exp 0000 1 0", grant, burst_done, wr_en); end
        run(2);
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 4'b0001; req_len[0 +: 12] = 12'd100; wr_valid = 1'b1;
        tick();
        req = 4'b0000;
        run(102);
        req = 4'b0001; req_len[0 +: 12] = 12'd10; free_valid = 1'b1; free_len = 12'd3;
        tick();
        checks++; if ({grant, usage} !== {4'b0001, 8'd107}) begin errors++; $display("FAIL sim_alloc_free got grant %b usage %0d exp 0001 107", grant, usage); end
        req = 4'b0000; free_valid = 1'b0;
        run(12);
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL sim_almost_full got %b exp 0", almost_full); end
        free_valid = 1'b1; free_len = 12'd200;
        tick();
        free_valid = 1'b0;
        checks++; if ({usage, free_err} !== {8'd0, 1'b1}) begin errors++; $display("FAIL sim_over_free got usage %0d err %b exp 0 1", usage, free_err); end
        run(3);
        checks++; if ({usage, free_err} !== {8'd0, 1'b1}) begin errors++; $display("FAIL sim_sticky got usage %0d err %b exp 0 1", usage, free_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001; req_len[0 +: 12] = 12'd6; wr_valid = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL arst_grant got %b exp 0001", grant); end
        req = 4'b0000;
        run(2);
        #2 reset = 1'b0;
        #1;
        checks++; if ({grant, usage, wr_en} !== {4'b0000, 8'd0, 1'b0}) begin errors++; $display("FAIL arst_now got grant %b usage %0d en %b exp 0000 0 0", grant, usage, wr_en); end
        @(negedge clk);
        reset = 1'b1;
        req = 4'b0001; req_len[0 +: 12] = 12'd1;
        tick();
        checks++; if ({grant, wr_en, wr_addr} !== {4'b0001, 1'b1, 8'h00}) begin errors++; $display("FAIL arst_after got grant %b en %b addr %h exp 0001 1 00", grant, wr_en, wr_addr); end
        req = 4'b0000;
        run(3);
    endtask

    initial begin
        reset = 1'b0; req = '0; req_len = '0; wr_valid = 1'b0;
        free_valid = 1'b0; free_len = '0;
        test_reset();
        test_single();
        test_contention();
        test_space();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
